// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg
//   Shared constants for the SPI file loader: the UIO file-transfer command
//   codes decoded from the IO-controller link, and the write-port state
//   encoding (also exported on the dbg_state port of spi_loader).
package spi_loader_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,   // no request on the RAM port
        WR_FWR  = 2'd1,   // writing a buffered download byte
        WR_EWR  = 2'd2    // writing a zero into the erase region
    } wr_state_t;

endpackage

// File: rtl/spi_loader_fifo.sv
// sync_fifo
//   Small single-clock FIFO holding {address, byte} pairs between the SPI
//   decoder and the RAM write port. Storage is a register array; o_data shows
//   the head entry whenever the FIFO is non-empty (show-ahead).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_push, i_data    write an entry (ignored while full)
//   i_pop             drop the head entry (ignored while empty)
//   o_data            head entry
//   o_full, o_empty   occupancy flags
module sync_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    // One extra pointer bit separates "full" from "empty" when indices match.
    logic [PW:0]  r_wr_ptr;
    logic [PW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/spi_loader.sv
// spi_loader
//   Receives UIO file downloads over the IO-controller SPI link (oversampled
//   in the clk domain), buffers the bytes and writes them to RAM. Index 0
//   loads at ROM_BASE, any other index at FILE_BASE. Ending an index-0
//   download, or a rising edge on force_erase, zero-fills ERASE_LEN bytes from
//   ERASE_BASE, one write every ERASE_DIV clocks at most; buffered download
//   bytes always take the RAM port first.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   sck, ss, sdi            raw SPI pins (asynchronous)
//   force_erase             level; rising edge starts an erase
//   downloading             download, erase or write still in progress
//   index, size, overflow   last file index, bytes accepted, sticky drop flag
//   wr, wr_ack, a, d        RAM write port
//   dbg_state               current write-port state (wr_state_t)
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int            AW         = 25,
    parameter int            FIFO_DEPTH = 4,
    parameter logic [AW-1:0] ROM_BASE   = 25'h178000,
    parameter logic [AW-1:0] FILE_BASE  = 25'h200000,
    parameter logic [AW-1:0] ERASE_BASE = 25'h1a0000,
    parameter logic [AW-1:0] ERASE_LEN  = 25'h20000,
    parameter int unsigned   ERASE_DIV  = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sck,
    input  logic          ss,
    input  logic          sdi,
    input  logic          force_erase,
    output logic          downloading,
    output logic [4:0]    index,
    output logic [AW-1:0] size,
    output logic          overflow,
    output logic          wr,
    input  logic          wr_ack,
    output logic [AW-1:0] a,
    output logic [7:0]    d,
    output logic [1:0]    dbg_state
);

    localparam logic [AW-1:0] ERASE_LAST = ERASE_BASE + ERASE_LEN - AW'(1);
    localparam logic [31:0]   DIV_RELOAD = 32'(ERASE_DIV - 1);
    localparam int            FW         = AW + 8;

    // SPI sampling and command decode
    logic [1:0]    r_sck_s;
    logic [1:0]    r_ss_s;
    logic [1:0]    r_sdi_s;
    logic          r_sck_d;
    logic [3:0]    r_bit_cnt;
    logic [6:0]    r_sreg;
    logic [7:0]    r_cmd;
    logic [4:0]    r_index;
    logic          r_dl;
    logic          r_overflow;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_size;
    logic          r_fe_s;
    logic          r_fe_d;

    // RAM write port and erase engine
    wr_state_t     r_state;
    logic          r_wr;
    logic [AW-1:0] r_a;
    logic [7:0]    r_d;
    logic          r_erase_pend;
    logic [AW-1:0] r_erase_ptr;
    logic [31:0]   r_div_cnt;

    logic          w_sck_rise;
    logic          w_bit_in;
    logic [7:0]    w_byte;
    logic          w_byte_done;
    logic          w_tx;
    logic          w_dat;
    logic          w_idx;
    logic          w_push;
    logic          w_erase_req;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [FW-1:0] w_fifo_q;
    logic          w_free;
    logic          w_pop;
    logic          w_take_erase;

    assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
    assign w_bit_in    = r_sdi_s[1];
    assign w_byte      = {r_sreg, w_bit_in};
    // Bits 0-7 form the command byte; 8-15 repeat for every data byte.
    assign w_byte_done = w_sck_rise & ~r_ss_s[1] & (r_bit_cnt == 4'd15);
    assign w_tx        = w_byte_done & (r_cmd == UIO_FILE_TX);
    assign w_dat       = w_byte_done & (r_cmd == UIO_FILE_TX_DAT);
    assign w_idx       = w_byte_done & (r_cmd == UIO_FILE_INDEX);
    assign w_push      = w_dat & ~w_fifo_full;
    assign w_erase_req = (ERASE_LEN != '0) &
                         ((w_tx & ~w_byte[0] & (r_index == 5'd0)) | (r_fe_s & ~r_fe_d));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_s    <= 2'b00;
            r_ss_s     <= 2'b11;
            r_sdi_s    <= 2'b00;
            r_sck_d    <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_sreg     <= 7'd0;
            r_cmd      <= 8'd0;
            r_index    <= 5'd0;
            r_dl       <= 1'b0;
            r_overflow <= 1'b0;
            r_addr     <= '0;
            r_size     <= '0;
            r_fe_s     <= 1'b0;
            r_fe_d     <= 1'b0;
        end else begin
            r_sck_s <= {r_sck_s[0], sck};
            r_ss_s  <= {r_ss_s[0], ss};
            r_sdi_s <= {r_sdi_s[0], sdi};
            r_sck_d <= r_sck_s[1];
            r_fe_s  <= force_erase;
            r_fe_d  <= r_fe_s;

            if (r_ss_s[1]) begin
                r_bit_cnt <= 4'd0;
            end else if (w_sck_rise) begin
                r_sreg    <= w_byte[6:0];
                r_bit_cnt <= (r_bit_cnt == 4'd15) ? 4'd8 : r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd7) r_cmd <= w_byte;
            end

            if (w_tx) begin
                if (w_byte[0]) begin
                    r_dl       <= 1'b1;
                    r_addr     <= (r_index == 5'd0) ? ROM_BASE : FILE_BASE;
                    r_size     <= '0;
                    r_overflow <= 1'b0;
                end else begin
                    r_dl <= 1'b0;
                end
            end

            if (w_dat) begin
                if (!w_fifo_full) begin
                    r_addr <= r_addr + AW'(1);
                    r_size <= r_size + AW'(1);
                end else begin
                    r_overflow <= 1'b1;
                end
            end

            if (w_idx) r_index <= w_byte[4:0];
        end
    end

    sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  ({r_addr, w_byte}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_q),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // RAM port handshake: a request is wr=1 with a/d held stable; it completes
    // on the cycle wr=1 and wr_ack=1. wr_ack is ignored while wr=0. The port is
    // free either when idle or on the completing cycle, so a following request
    // can be loaded with wr kept high.
    assign w_free       = (r_state == WR_IDLE) | (r_wr & wr_ack);
    assign w_pop        = w_free & ~w_fifo_empty;
    // Erase never chains straight out of an erase write, so the pointer is
    // always up to date when it is presented on a.
    assign w_take_erase = w_free & w_fifo_empty & r_erase_pend &
                          (r_div_cnt == 32'd0) & (r_state != WR_EWR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= WR_IDLE;
            r_wr         <= 1'b0;
            r_a          <= '0;
            r_d          <= 8'd0;
            r_erase_pend <= 1'b0;
            r_erase_ptr  <= '0;
            r_div_cnt    <= 32'd0;
        end else begin
            if (w_pop) begin
                r_state <= WR_FWR;
                r_wr    <= 1'b1;
                r_a     <= w_fifo_q[FW-1:8];
                r_d     <= w_fifo_q[7:0];
            end else if (w_take_erase) begin
                r_state <= WR_EWR;
                r_wr    <= 1'b1;
                r_a     <= r_erase_ptr;
                r_d     <= 8'd0;
            end else if (w_free) begin
                r_state <= WR_IDLE;
                r_wr    <= 1'b0;
            end

            if (w_take_erase) begin
                r_div_cnt <= DIV_RELOAD;
            end else if (r_div_cnt != 32'd0) begin
                r_div_cnt <= r_div_cnt - 32'd1;
            end

            // A restart while an erase write is in flight has already moved the
            // pointer back to ERASE_BASE; only advance if it still matches.
            if ((r_state == WR_EWR) && wr_ack && (r_a == r_erase_ptr)) begin
                if (r_erase_ptr == ERASE_LAST) begin
                    r_erase_pend <= 1'b0;
                end else begin
                    r_erase_ptr <= r_erase_ptr + AW'(1);
                end
            end

            if (w_erase_req) begin
                r_erase_pend <= 1'b1;
                r_erase_ptr  <= ERASE_BASE;
            end
        end
    end

    assign downloading = r_dl | r_erase_pend | ~w_fifo_empty | (r_state != WR_IDLE);
    assign index       = r_index;
    assign size        = r_size;
    assign overflow    = r_overflow;
    assign wr          = r_wr;
    assign a           = r_a;
    assign d           = r_d;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_loader.sv
module tb_spi_loader;

    localparam int            AW         = 25;
    localparam int            FIFO_DEPTH = 4;
    localparam logic [AW-1:0] ROM_BASE   = 25'h178000;
    localparam logic [AW-1:0] FILE_BASE  = 25'h200000;
    localparam logic [AW-1:0] ERASE_BASE = 25'h1a0000;
    localparam logic [AW-1:0] ERASE_LEN  = 25'd4;
    localparam int            ERASE_DIV  = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset_n;
    logic          sck, ss, sdi, force_erase, wr_ack;
    logic          downloading, overflow, wr;
    logic [4:0]    index;
    logic [AW-1:0] size, a;
    logic [7:0]    d;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    spi_loader #(
        .AW         (AW),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ROM_BASE   (ROM_BASE),
        .FILE_BASE  (FILE_BASE),
        .ERASE_BASE (ERASE_BASE),
        .ERASE_LEN  (ERASE_LEN),
        .ERASE_DIV  (ERASE_DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sck         (sck),
        .ss          (ss),
        .sdi         (sdi),
        .force_erase (force_erase),
        .downloading (downloading),
        .index       (index),
        .size        (size),
        .overflow    (overflow),
        .wr          (wr),
        .wr_ack      (wr_ack),
        .a           (a),
        .d           (d),
        .dbg_state   (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // ack_mode: 0 = always 1, 1 = held 0, 2 = random
    int ack_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       wr_ack = 1'b1;
            1:       wr_ack = 1'b0;
            default: wr_ack = ($urandom_range(0, 2) == 0);
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic [AW+7:0] exp_q[$];
    logic [AW+7:0] act_data_q[$];
    logic [AW-1:0] act_erase_q[$];
    logic [7:0]    act_erase_d_q[$];
    int            erase_start_cyc[$];
    int            cyc = 0;
    int            hold_viol = 0;
    logic          prev_wr = 1'b0;
    logic          prev_ack = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [7:0]    prev_d = '0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_wr  = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (wr && (!prev_wr || prev_ack) && (a >= ERASE_BASE) && (a < ERASE_BASE + ERASE_LEN))
                erase_start_cyc.push_back(cyc);
            if (wr && prev_wr && !prev_ack && ((a !== prev_a) || (d !== prev_d)))
                hold_viol++;
            if (wr && wr_ack) begin
                if ((a >= ERASE_BASE) && (a < ERASE_BASE + ERASE_LEN)) begin
                    act_erase_q.push_back(a);
                    act_erase_d_q.push_back(d);
                end else begin
                    act_data_q.push_back({a, d});
                end
            end
            prev_wr  = wr;
            prev_ack = wr_ack;
            prev_a   = a;
            prev_d   = d;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sdi = b[i];
            #40 sck = 1'b1;
            #40 sck = 1'b0;
        end
    endtask

    task automatic spi_begin();
        ss = 1'b0;
        #40;
    endtask

    task automatic spi_end();
        #40 ss = 1'b1;
        #160;
    endtask

    task automatic send_cmd1(input logic [7:0] cmd, input logic [7:0] b);
        spi_begin();
        spi_byte(cmd);
        spi_byte(b);
        spi_end();
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!downloading && !wr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        act_data_q.delete();
        act_erase_q.delete();
        act_erase_d_q.delete();
        erase_start_cyc.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n     = 1'b0;
        sck         = 1'b0;
        ss          = 1'b1;
        sdi         = 1'b0;
        force_erase = 1'b0;
        ack_mode    = 0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        checks++; if (wr !== 1'b0)          begin failures++; $display("FAIL reset_wr got=%b exp=0", wr); end
        checks++; if (a !== '0)             begin failures++; $display("FAIL reset_a got=%h exp=0", a); end
        checks++; if (d !== 8'd0)           begin failures++; $display("FAIL reset_d got=%h exp=0", d); end
        checks++; if (downloading !== 1'b0) begin failures++; $display("FAIL reset_downloading got=%b exp=0", downloading); end
        checks++; if (index !== 5'd0)       begin failures++; $display("FAIL reset_index got=%0d exp=0", index); end
        checks++; if (size !== '0)          begin failures++; $display("FAIL reset_size got=%0d exp=0", size); end
        checks++; if (overflow !== 1'b0)    begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (dbg_state !== 2'd0)   begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_file_download();
        logic [4:0] idx;
        logic [7:0] b;
        int         n;
        bit         ok;
        clear_sb();
        ack_mode = 0;
        idx = 5'($urandom_range(1, 31));
        n   = $urandom_range(3, 6);
        send_cmd1(8'h55, {3'($urandom_range(0, 7)), idx});
        send_cmd1(8'h53, 8'h01);
        checks++; if (downloading !== 1'b1) begin failures++; $display("FAIL dl_active got=%b exp=1", downloading); end
        checks++; if (size !== '0)          begin failures++; $display("FAIL dl_size_start got=%0d exp=0", size); end
        spi_begin();
        spi_byte(8'h54);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back({FILE_BASE + AW'(i), b});
            spi_byte(b);
        end
        spi_end();
        checks++; if (size !== AW'(n)) begin failures++; $display("FAIL dl_size got=%0d exp=%0d", size, n); end
        send_cmd1(8'h53, 8'h00);
        wait_idle(500, ok);
        checks++; if (!ok)          begin failures++; $display("FAIL dl_idle got=busy exp=idle"); end
        checks++; if (index !== idx) begin failures++; $display("FAIL dl_index got=%0d exp=%0d", index, idx); end
        checks++;
        if (act_data_q.size() != exp_q.size()) begin
            failures++; $display("FAIL dl_count got=%0d exp=%0d", act_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_data_q.size(); i++) begin
            checks++;
            if (act_data_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL dl_write[%0d] got=%h exp=%h", i, act_data_q[i], exp_q[i]);
            end
        end
        checks++; if (act_erase_q.size() != 0) begin failures++; $display("FAIL dl_no_erase got=%0d exp=0", act_erase_q.size()); end
    endtask

    task automatic test_rom_erase();
        logic [7:0] b;
        bit         ok;
        clear_sb();
        ack_mode = 2;
        send_cmd1(8'h55, {3'($urandom_range(0, 7)), 5'd0});
        send_cmd1(8'h53, 8'h01);
        b = 8'($urandom);
        exp_q.push_back({ROM_BASE, b});
        send_cmd1(8'h54, b);
        send_cmd1(8'h53, 8'h00);
        checks++; if (downloading !== 1'b1) begin failures++; $display("FAIL rom_erase_active got=%b exp=1", downloading); end
        wait_idle(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rom_idle got=busy exp=idle"); end
        checks++;
        if (act_data_q.size() != 1 || act_data_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL rom_write got_n=%0d exp=%h", act_data_q.size(), exp_q[0]);
        end
        checks++;
        if (act_erase_q.size() != int'(ERASE_LEN)) begin
            failures++; $display("FAIL rom_erase_count got=%0d exp=%0d", act_erase_q.size(), ERASE_LEN);
        end
        for (int i = 0; i < act_erase_q.size(); i++) begin
            checks++;
            if (act_erase_q[i] !== ERASE_BASE + AW'(i) || act_erase_d_q[i] !== 8'd0) begin
                failures++; $display("FAIL rom_erase[%0d] got=%h/%h exp=%h/00", i, act_erase_q[i], act_erase_d_q[i], ERASE_BASE + AW'(i));
            end
        end
        for (int i = 1; i < erase_start_cyc.size(); i++) begin
            checks++;
            if (erase_start_cyc[i] - erase_start_cyc[i-1] < ERASE_DIV) begin
                failures++; $display("FAIL rom_erase_spacing got=%0d exp>=%0d", erase_start_cyc[i] - erase_start_cyc[i-1], ERASE_DIV);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] first;
        bit         ok;
        clear_sb();
        hold_viol = 0;
        ack_mode  = 1;
        first     = 8'd0;
        send_cmd1(8'h55, 8'($urandom_range(1, 31)));
        send_cmd1(8'h53, 8'h01);
        spi_begin();
        spi_byte(8'h54);
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            b = 8'($urandom);
            if (i == 0) first = b;
            if (i < FIFO_DEPTH + 1) exp_q.push_back({FILE_BASE + AW'(i), b});
            spi_byte(b);
        end
        spi_end();
        checks++; if (size !== AW'(FIFO_DEPTH + 1)) begin failures++; $display("FAIL ovf_size got=%0d exp=%0d", size, FIFO_DEPTH + 1); end
        checks++; if (overflow !== 1'b1)            begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (wr !== 1'b1 || a !== FILE_BASE || d !== first) begin
            failures++; $display("FAIL ovf_held got=%b/%h/%h exp=1/%h/%h", wr, a, d, FILE_BASE, first);
        end
        checks++; if (act_data_q.size() != 0) begin failures++; $display("FAIL ovf_no_write got=%0d exp=0", act_data_q.size()); end
        ack_mode = 0;
        send_cmd1(8'h53, 8'h00);
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL ovf_idle got=busy exp=idle"); end
        checks++;
        if (act_data_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_count got=%0d exp=%0d", act_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_data_q.size(); i++) begin
            checks++;
            if (act_data_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL ovf_write[%0d] got=%h exp=%h", i, act_data_q[i], exp_q[i]);
            end
        end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL ovf_hold got=%0d exp=0", hold_viol); end
        send_cmd1(8'h53, 8'h01);
        checks++; if (overflow !== 1'b0 || size !== '0) begin
            failures++; $display("FAIL ovf_restart got=%b/%0d exp=0/0", overflow, size);
        end
        send_cmd1(8'h53, 8'h00);
        wait_idle(500, ok);
    endtask

    task automatic test_force_erase();
        logic [7:0] b;
        int         n;
        bit         ok;
        clear_sb();
        hold_viol = 0;
        ack_mode  = 2;
        n = $urandom_range(6, 10);
        send_cmd1(8'h55, 8'($urandom_range(1, 31)));
        send_cmd1(8'h53, 8'h01);
        spi_begin();
        spi_byte(8'h54);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back({FILE_BASE + AW'(i), b});
            if (i == 1) force_erase = 1'b1;
            if (i == 3) force_erase = 1'b0;
            spi_byte(b);
        end
        spi_end();
        send_cmd1(8'h53, 8'h00);
        wait_idle(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fe_idle got=busy exp=idle"); end
        checks++;
        if (act_data_q.size() != exp_q.size()) begin
            failures++; $display("FAIL fe_count got=%0d exp=%0d", act_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_data_q.size(); i++) begin
            checks++;
            if (act_data_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL fe_write[%0d] got=%h exp=%h", i, act_data_q[i], exp_q[i]);
            end
        end
        checks++;
        if (act_erase_q.size() != int'(ERASE_LEN)) begin
            failures++; $display("FAIL fe_erase_count got=%0d exp=%0d", act_erase_q.size(), ERASE_LEN);
        end
        for (int i = 0; i < act_erase_q.size(); i++) begin
            checks++;
            if (act_erase_q[i] !== ERASE_BASE + AW'(i) || act_erase_d_q[i] !== 8'd0) begin
                failures++; $display("FAIL fe_erase[%0d] got=%h/%h exp=%h/00", i, act_erase_q[i], act_erase_d_q[i], ERASE_BASE + AW'(i));
            end
        end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL fe_hold got=%0d exp=0", hold_viol); end
    endtask

    task automatic test_erase_restart();
        int  k;
        int  p;
        bit  ok;
        clear_sb();
        ack_mode = 0;
        @(negedge clk);
        force_erase = 1'b1;
        repeat (3) @(negedge clk);
        force_erase = 1'b0;
        checks++; if (downloading !== 1'b1) begin failures++; $display("FAIL rs_active got=%b exp=1", downloading); end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (act_erase_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL rs_first_two got=%0d exp>=2", act_erase_q.size()); end
        force_erase = 1'b1;
        repeat (3) @(negedge clk);
        force_erase = 1'b0;
        wait_idle(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rs_idle got=busy exp=idle"); end
        k = act_erase_q.size();
        p = k - int'(ERASE_LEN);
        checks++;
        if (p < 2 || p > 4) begin
            failures++; $display("FAIL rs_count got=%0d exp=6..8", k);
        end else begin
            for (int i = 0; i < k; i++) begin
                checks++;
                if (act_erase_q[i] !== ERASE_BASE + AW'((i < p) ? i : i - p) || act_erase_d_q[i] !== 8'd0) begin
                    failures++; $display("FAIL rs_erase[%0d] got=%h/%h exp=%h/00", i, act_erase_q[i], act_erase_d_q[i],
                                         ERASE_BASE + AW'((i < p) ? i : i - p));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_sb();
        ack_mode = 1;
        send_cmd1(8'h55, 8'($urandom_range(1, 31)));
        send_cmd1(8'h53, 8'h01);
        spi_begin();
        spi_byte(8'h54);
        spi_byte(8'($urandom));
        spi_byte(8'($urandom));
        spi_end();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin failures++; $display("FAIL rm_wr_up got=0 exp=1"); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (wr !== 1'b0)          begin failures++; $display("FAIL rm_wr got=%b exp=0", wr); end
        checks++; if (size !== '0)          begin failures++; $display("FAIL rm_size got=%0d exp=0", size); end
        checks++; if (index !== 5'd0)       begin failures++; $display("FAIL rm_index got=%0d exp=0", index); end
        checks++; if (downloading !== 1'b0) begin failures++; $display("FAIL rm_downloading got=%b exp=0", downloading); end
        ack_mode = 0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (wr !== 1'b0 || downloading !== 1'b0) begin
            failures++; $display("FAIL rm_after got=%b/%b exp=0/0", wr, downloading);
        end
        checks++; if (act_data_q.size() != 0) begin failures++; $display("FAIL rm_no_write got=%0d exp=0", act_data_q.size()); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_file_download();
        test_rom_erase();
        test_overflow();
        test_force_erase();
        test_erase_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_loader.md
# spi_loader

Single-clock, parametrised successor to the MiST file-download receiver. It oversamples the IO-controller SPI link in the system clock domain, decodes the UIO file-transfer commands and buffers received bytes in a small FIFO. It then writes them to external RAM through a ready/ack write port, with per-index base addresses and a configurable zero-erase region. It sits between the IO-controller pins and the SDRAM arbiter.

## Interface
Parameters:
- AW, 25, RAM address width
- FIFO_DEPTH, 4, byte buffer depth (power of two, ≥2)
- ROM_BASE, 25'h178000, load address for index 0
- FILE_BASE, 25'h200000, load address for index ≠ 0
- ERASE_BASE, 25'h1a0000, first erased address
- ERASE_LEN, 25'h20000, bytes erased; 0 disables erase
- ERASE_DIV, 32, clk cycles between erase write requests (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sck, ss, sdi  in  1 each  raw SPI pins (asynchronous to clk)
- force_erase  in  1  level; rising edge starts an erase
- downloading  out  1  download active or erase active
- index  out  5  menu index from last UIO_FILE_INDEX
- size  out  AW  bytes accepted since last download start
- overflow  out  1  sticky: a byte was dropped (FIFO full)
- wr  out  1  write request
- wr_ack  in  1  RAM accepted current request
- a  out  AW  write address
- d  out  8  write data

## Operation
- sck/ss/sdi pass through 2-FF synchronisers; sck rising edge detected from synced samples; sdi sampled on that edge.
- Synced ss high clears bit counter; counter runs 0-7 (command byte), then 8-15 repeating (data bytes).
- Commands: 0x53 UIO_FILE_TX, 0x54 UIO_FILE_TX_DAT, 0x55 UIO_FILE_INDEX; others ignored.
- 0x53 data bit0=1: load addr with ROM_BASE (index==0) else FILE_BASE; size←0; overflow←0; download flag←1. bit0=0: flag←0; if index==0 and ERASE_LEN≠0, request erase.
- 0x54: each byte pushes {addr,byte} into FIFO, addr+1, size+1. FIFO full: byte dropped, addr/size unchanged, overflow←1.
- 0x55: index←byte[4:0].
- Write FSM states IDLE, FWR, EWR:
  - IDLE: FIFO non-empty → FWR (pop, drive a/d). Else erase pending and divider expired → EWR (a=erase_ptr, d=0).
  - FWR/EWR: hold wr=1, a, d stable until wr_ack=1; then back to IDLE (erase_ptr+1 after EWR).
- FIFO writes always win over erase writes; erase resumes after FIFO drains.
- Erase ends after ERASE_BASE+ERASE_LEN-1 is acknowledged. New erase request mid-erase restarts from ERASE_BASE. Erase pointer never wraps past its range.
- downloading = download flag | erase pending | FIFO non-empty | FSM≠IDLE.

## Timing
- Reset: wr=0, a=0, d=0, downloading=0, index=0, size=0, overflow=0; FIFO empty; FSM IDLE; no erase pending.
- clk must be ≥4× sck; sck edge recognised 3 clk after pin edge.
- Byte push on the cycle its 8th bit is sampled; wr rises the next cycle if FIFO was empty and FSM IDLE.
- Transfer completes on the cycle wr=1 & wr_ack=1. Next request may assert the following cycle: wr stays high, new a/d.
- wr_ack while wr=0 is ignored.
- force_erase edge detected one cycle after a registered sample.
- reset_n low mid-transfer aborts all state immediately; a held wr_ack is ignored after release.

## Structure
- Package spi_loader_pkg: UIO_FILE_TX/UIO_FILE_TX_DAT/UIO_FILE_INDEX constants, write-FSM state enum.
- Sub-module sync_fifo (width AW+8, depth FIFO_DEPTH, full/empty, registered output). SPI decode and write FSM stay in spi_loader.

## Test plan
- Index 0x02, 0x53 bit1, 3 bytes AA/BB/CC with wr_ack tied 1 → writes 0x200000=AA, 0x200001=BB, 0x200002=CC; size=3; downloading falls after 0x53 bit0.
- Index 0, 0x53 start, 1 byte, 0x53 end, ERASE_LEN=4 → write 0x178000, then zeros to 0x1a0000-0x1a0003 spaced ≥ERASE_DIV; downloading low after last ack.
- wr_ack held 0 with FIFO_DEPTH=4, send 6 bytes → first 5 accepted (1 in FSM + 4 buffered), 6th dropped, overflow=1, size=5; release ack → 5 writes in order.
- Force_erase during download → FIFO writes preempt erase writes; all data bytes land intact; erase completes afterwards.
- reset_n pulsed low during FWR with wr_ack=0 → wr=0, size=0, index=0, downloading=0 immediately.
